// File: rtl/env_decay_sweeper_pkg.sv
// env_decay_sweeper_pkg: geometry, sweeper state, cell word and saturating decay shared by the sweeper files.
package env_decay_sweeper_pkg;
    localparam int PIXELS_X    = 4;
    localparam int PIXELS_Y    = 2;
    localparam int X_bits      = 2;
    localparam int Y_bits      = 1;
    localparam int SIGNAL_bits = 4;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} sweep_state_t;
    typedef struct packed {
        logic [SIGNAL_bits-1:0] signal;
        logic                   sugar;
    } cell_t;
    function automatic logic [SIGNAL_bits-1:0] sat_sub(input logic [SIGNAL_bits-1:0] s, input logic [SIGNAL_bits-1:0] d);
        return (s > d) ? s - d : '0;
    endfunction
endpackage

// File: rtl/env_decay_sweeper_if.sv
// env_decay_sweeper_if: lookup and shared write port between the sweeper (master) and the environment array (slave).
interface env_decay_sweeper_if;
    import env_decay_sweeper_pkg::*;
    logic [X_bits-1:0]      lookup_X;
    logic [Y_bits-1:0]      lookup_Y;
    logic [SIGNAL_bits:0]   lookup_data;
    logic                   write_req;
    logic                   write_grant;
    logic                   write_en;
    logic [X_bits-1:0]      write_X;
    logic [Y_bits-1:0]      write_Y;
    logic [SIGNAL_bits-1:0] write_signal;
    logic                   write_sugar;
    modport master (
        output lookup_X, lookup_Y, write_req, write_en, write_X, write_Y, write_signal, write_sugar,
        input  lookup_data, write_grant
    );
    modport slave (
        input  lookup_X, lookup_Y, write_req, write_en, write_X, write_Y, write_signal, write_sugar,
        output lookup_data, write_grant
    );
endinterface

// File: rtl/env_scan_counter.sv
// env_scan_counter: raster X/Y counter with clear, advance and last-cell flag.
module env_scan_counter #(
    parameter int NX = 4,
    parameter int NY = 2,
    parameter int XW = 2,
    parameter int YW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_xend;
    assign w_xend = r_x == XW'(NX - 1);
    assign o_last = w_xend && (r_y == YW'(NY - 1));
    assign o_x    = r_x;
    assign o_y    = r_y;
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            r_x <= w_xend ? '0 : r_x + 1'b1;
            r_y <= w_xend ? r_y + 1'b1 : r_y;
        end
    end
endmodule

// File: rtl/env_decay_sweeper.sv
// env_decay_sweeper: raster-order pheromone decay sweep sharing the array write port with the ants.
// Optional ENV_DECAY_SKIP_ZERO_EN: cells whose signal is already 0 are not rewritten.
module env_decay_sweeper
    import env_decay_sweeper_pkg::*;
(
    input  logic                   newLocClock,
    input  logic                   RESET_SIM_N,
    input  logic                   start_sweep,
    input  logic [SIGNAL_bits-1:0] decay_amount,
    output logic                   busy,
    output logic                   done,
    env_decay_sweeper_if.master    bus
);
    sweep_state_t           r_state, w_next;
    logic [SIGNAL_bits-1:0] r_d, r_sig;
    logic                   r_sugar;
    logic [X_bits-1:0]      w_x;
    logic [Y_bits-1:0]      w_y;
    logic                   w_last, w_clr, w_adv, w_skip, w_wr_ok;
    cell_t                  w_cell;
    assign w_cell  = bus.lookup_data;
    assign w_clr   = (r_state == IDLE) && start_sweep;
    assign w_wr_ok = (r_state == WRITE) && bus.write_grant;
`ifdef ENV_DECAY_SKIP_ZERO_EN
    assign w_skip  = (r_state == READ) && (w_cell.signal == '0);
`else
    assign w_skip  = 1'b0;
`endif
    // The final cell never advances, so lookup_X/lookup_Y stay on it through DONE and IDLE.
    assign w_adv   = !w_last && (w_wr_ok || w_skip);
    env_scan_counter #(
        .NX(PIXELS_X), .NY(PIXELS_Y), .XW(X_bits), .YW(Y_bits)
    ) u_scan (
        .clk(newLocClock), .rst_n(RESET_SIM_N), .i_clr(w_clr), .i_adv(w_adv),
        .o_x(w_x), .o_y(w_y), .o_last(w_last)
    );
    always_ff @(posedge newLocClock) begin
        if (!RESET_SIM_N)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // A denied write goes back to READ so a concurrent ant deposit is picked up.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_sweep ? READ : IDLE;
            READ:    w_next = w_skip ? (w_last ? DONE : READ) : WRITE;
            WRITE:   w_next = bus.write_grant ? (w_last ? DONE : READ) : READ;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge newLocClock) begin
        if (!RESET_SIM_N) begin
            r_d     <= '0;
            r_sig   <= '0;
            r_sugar <= 1'b0;
        end else begin
            if (w_clr)
                r_d <= decay_amount;
            if (r_state == READ) begin
                r_sig   <= sat_sub(w_cell.signal, r_d);
                r_sugar <= w_cell.sugar;
            end
        end
    end
    always_comb begin
        busy             = r_state != IDLE;
        done             = r_state == DONE;
        bus.write_req    = r_state == WRITE;
        bus.write_en     = w_wr_ok;
        bus.lookup_X     = w_x;
        bus.lookup_Y     = w_y;
        bus.write_X      = w_x;
        bus.write_Y      = w_y;
        bus.write_signal = r_sig;
        bus.write_sugar  = r_sugar;
    end
endmodule

// File: tb/tb_env_decay_sweeper.sv
// tb_env_decay_sweeper: directed scenarios against a small array model driving lookup_data and grant.
module tb_env_decay_sweeper;
    import env_decay_sweeper_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] decay = '0;
    logic       busy, done;
    logic [4:0] mem [8];
    int         log_idx [16];
    logic [4:0] log_val [16];
    int         nw, n_done, t_done, reset_hit;
    int         n_cmp = 0;
    int         n_err = 0;

    env_decay_sweeper_if bus();
    assign bus.lookup_data = mem[{bus.lookup_Y, bus.lookup_X}];

    env_decay_sweeper dut (
        .newLocClock(clk), .RESET_SIM_N(rst_n), .start_sweep(start), .decay_amount(decay),
        .busy(busy), .done(done), .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic fill(input logic [4:0] v);
        for (int i = 0; i < 8; i++) mem[i] = v;
    endtask

    // Runs one sweep; the array model applies each granted write and optionally stalls, restarts or resets.
    task automatic sweep(input logic [3:0] d, input int max_cyc, input int stall_idx, input int n_stall,
                         input int restart_t, input int reset_idx);
        int         stalls;
        logic [2:0] c;
        nw = 0; n_done = 0; t_done = -1; reset_hit = 0; stalls = n_stall;
        @(negedge clk);
        start = 1'b1; decay = d;
        for (int t = 1; t <= max_cyc; t++) begin
            @(negedge clk);
            start = (t == restart_t);
            decay = 4'hF;
            c = {bus.write_Y, bus.write_X};
            if (bus.write_req && int'(c) == reset_idx) begin
                bus.write_grant = 1'b0;
                rst_n = 1'b0;
                reset_hit = 1;
                break;
            end
            if (bus.write_req && int'(c) == stall_idx && stalls > 0) begin
                if (stalls == n_stall) mem[c] = {4'd9, mem[c][0]};
                stalls--;
                bus.write_grant = 1'b0;
            end else
                bus.write_grant = 1'b1;
            #1;
            if (bus.write_en === 1'b1 && nw < 16) begin
                log_idx[nw] = int'(c);
                log_val[nw] = {bus.write_signal, bus.write_sugar};
                mem[c] = log_val[nw];
                nw++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (t_done < 0) t_done = t;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; bus.write_grant = 1'b0;
        fill(5'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_status: busy/done=%b expected 00", {busy, done}); end
        n_cmp++;
        if ({bus.write_req, bus.write_en, bus.lookup_X, bus.lookup_Y, bus.write_X, bus.write_Y, bus.write_signal, bus.write_sugar} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_bus: req=%b en=%b lx=%0d ly=%0d wx=%0d wy=%0d sig=%0d sug=%b expected all 0",
                     bus.write_req, bus.write_en, bus.lookup_X, bus.lookup_Y, bus.write_X, bus.write_Y, bus.write_signal, bus.write_sugar);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        fill({4'd5, 1'b0});
        sweep(4'd2, 21, -1, 0, 0, -1);
        n_cmp++;
        if (t_done !== 17) begin n_err++; $display("FAIL basic_done_time: got %0d expected 17", t_done); end
        n_cmp++;
        if (n_done !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
        n_cmp++;
        if (nw !== 8) begin n_err++; $display("FAIL basic_write_count: got %0d expected 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (log_idx[i] !== i || log_val[i] !== {4'd3, 1'b0}) begin
                n_err++;
                $display("FAIL basic_write%0d: cell %0d value %h expected cell %0d value 06", i, log_idx[i], log_val[i], i);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_saturation;
        logic [4:0] init [8];
        logic [4:0] want [8];
        init = '{{4'd7,1'b0}, {4'd2,1'b1}, {4'd1,1'b1}, {4'd3,1'b0}, {4'd2,1'b1}, {4'd15,1'b0}, {4'd4,1'b1}, {4'd9,1'b0}};
        want = '{{4'd4,1'b0}, {4'd0,1'b1}, {4'd0,1'b1}, {4'd0,1'b0}, {4'd0,1'b1}, {4'd12,1'b0}, {4'd1,1'b1}, {4'd6,1'b0}};
        mem = init;
        sweep(4'd3, 20, -1, 0, 0, -1);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[i] !== want[i]) begin n_err++; $display("FAIL sat_cell%0d: got %h expected %h", i, mem[i], want[i]); end
        end
        n_cmp++;
        if (nw !== 8) begin n_err++; $display("FAIL sat_write_count: got %0d expected 8", nw); end
    endtask

    task automatic test_grant_stall;
        fill({4'd5, 1'b0});
        sweep(4'd2, 27, 1, 3, 0, -1);
        n_cmp++;
        if (t_done !== 23) begin n_err++; $display("FAIL stall_done_time: got %0d expected 23", t_done); end
        n_cmp++;
        if (nw !== 8) begin n_err++; $display("FAIL stall_write_count: got %0d expected 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (log_idx[i] !== i) begin n_err++; $display("FAIL stall_order%0d: got cell %0d expected %0d", i, log_idx[i], i); end
        end
        n_cmp++;
        if (mem[1] !== {4'd7, 1'b0}) begin n_err++; $display("FAIL stall_reread: got %h expected 0e", mem[1]); end
        n_cmp++;
        if (mem[2] !== {4'd3, 1'b0}) begin n_err++; $display("FAIL stall_next_cell: got %h expected 06", mem[2]); end
    endtask

    task automatic test_start_busy;
        fill({4'd6, 1'b1});
        sweep(4'd2, 24, -1, 0, 5, -1);
        n_cmp++;
        if (n_done !== 1 || t_done !== 17) begin n_err++; $display("FAIL busy_start_done: count %0d at %0d expected 1 at 17", n_done, t_done); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[i] !== {4'd4, 1'b1}) begin n_err++; $display("FAIL busy_start_cell%0d: got %h expected 09", i, mem[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int extra_done;
        fill({4'd5, 1'b0});
        sweep(4'd2, 20, -1, 0, 0, 3);
        n_cmp++;
        if (reset_hit !== 1) begin n_err++; $display("FAIL midreset_reached: got %0d expected 1", reset_hit); end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, bus.write_req, bus.write_en, bus.lookup_X, bus.lookup_Y, bus.write_X, bus.write_Y, bus.write_signal, bus.write_sugar} !== 17'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: busy=%b done=%b req=%b lx=%0d ly=%0d sig=%0d expected all 0",
                     busy, done, bus.write_req, bus.lookup_X, bus.lookup_Y, bus.write_signal);
        end
        rst_n = 1'b1;
        extra_done = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        n_cmp++;
        if (extra_done !== 0) begin n_err++; $display("FAIL midreset_idle: busy/done seen %0d cycles expected 0", extra_done); end
        n_cmp++;
        if (mem[2] !== {4'd3, 1'b0} || mem[3] !== {4'd5, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_cells: cell2 %h cell3 %h expected 06 0a", mem[2], mem[3]);
        end
        fill({4'd8, 1'b0});
        sweep(4'd1, 20, -1, 0, 0, -1);
        n_cmp++;
        if (log_idx[0] !== 0 || t_done !== 17) begin n_err++; $display("FAIL midreset_restart: first cell %0d done %0d expected 0 and 17", log_idx[0], t_done); end
        n_cmp++;
        if (mem[0] !== {4'd7, 1'b0}) begin n_err++; $display("FAIL midreset_restart_val: got %h expected 0e", mem[0]); end
    endtask

    task automatic test_skip_zero;
        fill({4'd5, 1'b0});
        mem[0] = {4'd0, 1'b1};
        mem[7] = {4'd0, 1'b1};
        sweep(4'd2, 21, -1, 0, 0, -1);
`ifdef ENV_DECAY_SKIP_ZERO_EN
        n_cmp++;
        if (t_done !== 15) begin n_err++; $display("FAIL skip_done_time: got %0d expected 15", t_done); end
        n_cmp++;
        if (nw !== 6 || log_idx[0] !== 1 || log_idx[5] !== 6) begin
            n_err++;
            $display("FAIL skip_writes: count %0d first %0d last %0d expected 6 1 6", nw, log_idx[0], log_idx[5]);
        end
`else
        n_cmp++;
        if (t_done !== 17) begin n_err++; $display("FAIL skip_done_time: got %0d expected 17", t_done); end
        n_cmp++;
        if (nw !== 8 || log_idx[0] !== 0 || log_idx[7] !== 7) begin
            n_err++;
            $display("FAIL skip_writes: count %0d first %0d last %0d expected 8 0 7", nw, log_idx[0], log_idx[7]);
        end
`endif
        n_cmp++;
        if (mem[0] !== {4'd0, 1'b1} || mem[1] !== {4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL skip_cells: cell0 %h cell1 %h expected 01 06", mem[0], mem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_grant_stall();
        test_start_busy();
        test_reset_mid();
        test_skip_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/env_decay_sweeper.md
Name: env_decay_sweeper

Overview:
- Pheromone evaporation engine sitting directly upstream of the environment row array's write port. It consumes the array's lookup port and feeds its write port.
- On a start pulse it walks every cell in raster order, reads {signal, sugar}, and subtracts a decay amount from the signal with saturation at zero. It writes the result back with sugar unchanged.
- Shares the environment write port with the ant-update logic. Ants have priority through an external grant.

Parameters:
- PIXELS_X, from params.sv, number of cells per row.
- PIXELS_Y, from params.sv, number of rows.
- X_bits, from params.sv, column index width.
- Y_bits, from params.sv, row index width.
- SIGNAL_bits, from params.sv, pheromone signal width. A cell word is SIGNAL_bits+1 bits: {signal, sugar}, with sugar in the LSB.

Ports:
- newLocClock  in  1  Sole clock, rising edge.
- RESET_SIM_N  in  1  Synchronous, active-low reset.
- start_sweep  in  1  Single-cycle request to begin a full sweep.
- decay_amount  in  SIGNAL_bits  Amount subtracted per cell. Sampled only on an accepted start.
- busy  out  1  High from the accepted start until the done cycle, inclusive.
- done  out  1  One-cycle pulse after the last cell is written.
- lookup_X  out  X_bits  Column address to the lookup port.
- lookup_Y  out  Y_bits  Row address to the lookup port. Decoded externally into per-row lookup flags.
- lookup_data  in  SIGNAL_bits+1  Cell word from the array. Combinational function of lookup_X and lookup_Y.
- write_req  out  1  Sweeper requests the shared write port.
- write_grant  in  1  Arbiter grant, combinational and same-cycle. Ants win ties.
- write_en  out  1  Equal to write_req AND write_grant.
- write_X  out  X_bits  Write column.
- write_Y  out  Y_bits  Write row.
- write_signal  out  SIGNAL_bits  Decayed signal.
- write_sugar  out  1  Sugar bit, copied unchanged.

Behaviour:
- Reset (RESET_SIM_N low at a clock edge):
  - State goes to IDLE and the cell counters clear to (0,0).
  - All outputs read 0 the following cycle.
  - Reset mid-sweep abandons the sweep with no done pulse. The cells already written stay written.
- States:
  - IDLE: busy=0. If start_sweep=1, latch decay_amount, set counters to (0,0) and go to READ.
  - READ: drive lookup_X/lookup_Y = counter. Register the saturating result and the sugar bit. Go to WRITE.
  - WRITE: write_req=1; write_X/write_Y = counter; write_signal and write_sugar come from the registered values.
    - If write_grant=1: write_en=1, then advance.
    - If write_grant=0: return to READ for the same cell, so an ant deposit made meanwhile is re-read and not overwritten.
  - Advance:
    - X increments first.
    - At X=PIXELS_X-1, X wraps to 0 and Y increments.
    - At (PIXELS_X-1, PIXELS_Y-1) go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Arithmetic: new = (signal > d) ? signal - d : 0, where d is the latched decay amount. No underflow wrap. d=0 rewrites every cell unchanged.
- Throughput: 2 cycles per cell when the grant is always high. A full sweep with no stalls takes 1 + 2·PIXELS_X·PIXELS_Y cycles from start to done.
- Start handling:
  - start_sweep while busy is ignored; the latched d is unchanged.
  - start_sweep during the DONE cycle is also ignored.
- write_req is never asserted outside WRITE. lookup_X/lookup_Y hold their last value outside READ.

Optional Feature:
- Macro: ENV_DECAY_SKIP_ZERO_EN.
- Defined: in READ, a cell with signal=0 skips WRITE entirely and advances directly. That cell takes 1 cycle and has no write_req. The last cell, if skipped, goes straight to DONE.
- Undefined: every cell is written, including zero cells.

Decomposition:
- The shared package holds:
  - the sweeper state enum typedef (IDLE, READ, WRITE, DONE);
  - a cell-word typedef {signal, sugar};
  - the saturating-subtract function.
- One natural sub-module: env_scan_counter, the X/Y raster counter with clear, advance and last-cell flag. It is reusable by the render scanner.

Test Plan (PIXELS_X=4, PIXELS_Y=2, SIGNAL_bits=4):
- Basic sweep:
  - Stimulus: all cells signal=5, sugar=0; d=2; grant tied high; pulse start.
  - Response: 8 writes in order (0,0)…(3,1), each writing 3; done exactly 17 cycles after the start edge; busy low afterwards.
- Saturation and sugar preservation:
  - Stimulus: cell (2,0)={1,1}, d=3.
  - Response: the write to (2,0) is signal=0, sugar=1; other cells are also saturated correctly.
- Grant stall:
  - Stimulus: grant low for 3 cycles at cell (1,0) while the model changes that cell to signal=9.
  - Response: sweeper re-reads and writes 7 (d=2), not the stale value; no other cell is skipped or duplicated.
- Start while busy:
  - Stimulus: second start with d=15 mid-sweep.
  - Response: ignored; all writes use d=2; exactly one done pulse.
- Reset mid-sweep:
  - Stimulus: RESET_SIM_N low at cell (3,0).
  - Response: next cycle all outputs are 0, state is IDLE and no done pulse occurs; a new start resumes from (0,0).
- ENV_DECAY_SKIP_ZERO_EN:
  - Stimulus: cells (0,0) and (3,1) set to 0, macro defined.
  - Response: no write_req for those two cells; done arrives at cycle 15.
  - Same stimulus with the macro undefined: 8 writes, done at cycle 17.
